nav_button_conditioner: RTL and testbench
=========================================

# nav_button_conditioner

Cleans the four raw board push-buttons and produces the direction levels and the human-rate step strobe that drive the cursor-position stage. Each button is synchronised and debounced. A single-cycle `move_tick` is then generated with press-and-hold auto-repeat and acceleration. The block sits between the board pins and the cursor-position stage: its `dir_*` outputs feed the button inputs, and its `move_tick` replaces the free-running human-rate clock.

## Interface
Parameters:
- `DEBOUNCE_CYC`, 500_000: consecutive stable cycles required to accept a new button level (10 ms @ 50 MHz).
- `FIRST_DELAY`, 25_000_000: cycles from the first step to the first auto-repeat step (500 ms).
- `SLOW_PERIOD`, 2_500_000: repeat interval before acceleration (50 ms).
- `FAST_PERIOD`, 500_000: repeat interval after acceleration (10 ms).
- `ACCEL_STEPS`, 16: number of slow repeats before switching to the fast interval.

Ports:
- Clocking and reset: one clock; reset is asynchronous and active-low.
  - `clk_in`, input, 1: system clock.
  - `rst_n`, input, 1: asynchronous active-low reset.
- Raw button inputs:
  - `BTN_EAST`, `BTN_WEST`, `BTN_NORTH`, `BTN_SOUTH`, input, 1 each: raw asynchronous button levels, active-high.
- Outputs:
  - `dir_east`, `dir_west`, `dir_north`, `dir_south`, output, 1 each: debounced registered button levels.
  - `move_tick`, output, 1: one-cycle step strobe; the downstream stage samples `dir_*` in the same cycle.
  - `repeat_fast`, output, 1: high while the fast repeat interval is active (status/LED).

## Operation
- **Synchronisation:** 2-FF synchroniser per button.
- **Debounce, per button:**
  - The counter clears whenever the synchronised level equals the current `dir_*`.
  - Otherwise it increments. On reaching `DEBOUNCE_CYC` the new level is accepted into `dir_*` and the counter clears.
  - Glitches shorter than `DEBOUNCE_CYC` cycles never reach `dir_*`.
- **Definitions:** `pat` = {`dir_east`, `dir_west`, `dir_north`, `dir_south`}; `pat_q` = `pat` delayed by one cycle.
- **Repeat FSM:** states IDLE, FIRST, SLOW, FAST; one interval counter; one repeat counter with width ≥ clog2(`ACCEL_STEPS`+1).
  - **IDLE:** `pat` ≠ 0 and `pat` ≠ `pat_q` → pulse `move_tick`, clear the interval counter, go to FIRST.
  - **FIRST:** counts to `FIRST_DELAY`; on expiry → pulse `move_tick`, clear the repeat counter, go to SLOW.
  - **SLOW:** every `SLOW_PERIOD` → pulse `move_tick`, increment the repeat counter; when it reaches `ACCEL_STEPS` → go to FAST.
  - **FAST:** every `FAST_PERIOD` → pulse `move_tick`. `repeat_fast` = 1 only in FAST.
  - **Any state:** `pat` = 0 → IDLE, with no tick and counters cleared.
  - **Any non-IDLE state:** `pat` ≠ 0 and `pat` ≠ `pat_q` (button added or removed) → immediate `move_tick`, restart FIRST.
- **Opposing buttons:** both may be high; the block passes them through unchanged and the downstream stage nets them.
- **Counters:** all counters saturate or clear as specified; none wraps.
- **Tick spacing:** at most one `move_tick` per cycle; ticks are never back-to-back.

## Timing
- **Reset:** all `dir_*` = 0, `move_tick` = 0, `repeat_fast` = 0, FSM in IDLE, all counters 0, synchronisers 0. Reset deassertion mid-press behaves like a fresh press once debounce completes.
- **Input-to-`dir` latency:** a clean input edge reaches `dir_*` 2 + `DEBOUNCE_CYC` cycles after the first sampling edge.
- **Tick latency:** `move_tick` asserts 1 cycle after the `pat` change, so `dir_*` are already stable in the tick cycle.
- **Repeat cadence:**
  - The first repeat tick comes `FIRST_DELAY` cycles after the initial tick.
  - Then `SLOW_PERIOD` apart, `ACCEL_STEPS` times.
  - Then `FAST_PERIOD` apart.
- **Release:** no tick is generated on release.
- **Release and expiry in the same cycle:** release wins, so there is no tick.

## Structure
- **Shared package `nav_pkg`:** the FSM state enum (IDLE/FIRST/SLOW/FAST) and default timing constants, shared with the cursor-position stage and top-level.
- **Sub-module `nav_debounce`:** synchroniser plus debounce counter for one button, instantiated four times. The FSM lives in the top module.

## Test plan
All scenarios use `DEBOUNCE_CYC`=4, `FIRST_DELAY`=20, `SLOW_PERIOD`=5, `FAST_PERIOD`=2, `ACCEL_STEPS`=3.
- **Reset:** hold `rst_n`=0 with all buttons high → all outputs 0. Release → `dir_*`=1 after 6 cycles, one tick at cycle 7.
- **Glitch rejection:** `BTN_EAST` high for 3 cycles, then low → `dir_east` stays 0, no tick.
- **Hold:** hold `BTN_NORTH` → ticks at relative cycles 0, 20, 25, 30, 35, 37, 39, …; `repeat_fast` rises at cycle 35.
- **Release mid-repeat:** release in SLOW → `dir_north` falls after 6 cycles, FSM to IDLE, no further ticks, `repeat_fast`=0.
- **Pattern change:** add `BTN_EAST` while `BTN_NORTH` is held in FAST → `dir_east`=1 and an immediate tick with `pat`=1010 on the cycle after. Next tick comes 20 cycles later; `repeat_fast`=0.
- **Async reset mid-operation:** assert `rst_n` during FAST → outputs clear in the same cycle, with no tick.

Source files
------------

// File: rtl/nav_pkg.sv
// nav_pkg: shared definitions for the navigation button path.
// Contents:
//   nav_state_e   - repeat FSM state encoding (IDLE/FIRST/SLOW/FAST)
//   NAV_*         - default timing constants for a 50 MHz clock
//   cnt_width()   - counter width able to hold 0..max_val
//   max3()        - largest of three integers (used to size shared counters)
package nav_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FIRST = 2'd1,
    ST_SLOW  = 2'd2,
    ST_FAST  = 2'd3
  } nav_state_e;

  localparam int NAV_DEBOUNCE_CYC = 500_000;
  localparam int NAV_FIRST_DELAY  = 25_000_000;
  localparam int NAV_SLOW_PERIOD  = 2_500_000;
  localparam int NAV_FAST_PERIOD  = 500_000;
  localparam int NAV_ACCEL_STEPS  = 16;

  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/nav_debounce.sv
// nav_debounce: 2-FF synchroniser plus debounce counter for one raw button.
// Ports:
//   i_clk    - system clock
//   i_rst_n  - asynchronous active-low reset
//   i_btn    - raw asynchronous button level
//   o_level  - debounced, registered button level
// A new level is accepted only after the synchronised input has differed
// from o_level for DEBOUNCE_CYC consecutive cycles.
module nav_debounce
  import nav_pkg::*;
#(
  parameter int DEBOUNCE_CYC = NAV_DEBOUNCE_CYC
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_btn,
  output logic o_level
);

  localparam int CNT_W = cnt_width(DEBOUNCE_CYC);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_level;
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_level <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
      if (r_sync2 == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        // this cycle is the DEBOUNCE_CYC-th consecutive differing sample
        r_level <= r_sync2;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_level = r_level;

endmodule

// File: rtl/nav_button_conditioner.sv
// nav_button_conditioner: debounces the four board buttons and produces the
// direction levels plus a one-cycle step strobe with hold auto-repeat and
// acceleration.
// Ports:
//   clk_in, rst_n                          - clock, async active-low reset
//   BTN_EAST/WEST/NORTH/SOUTH              - raw active-high buttons
//   dir_east/west/north/south              - debounced button levels
//   move_tick                              - one-cycle step strobe
//   repeat_fast                            - high while in the fast repeat phase
// The strobe is registered, so it appears the cycle after the pattern
// change and dir_* are already stable while it is high.
module nav_button_conditioner
  import nav_pkg::*;
#(
  parameter int DEBOUNCE_CYC = NAV_DEBOUNCE_CYC,
  parameter int FIRST_DELAY  = NAV_FIRST_DELAY,
  parameter int SLOW_PERIOD  = NAV_SLOW_PERIOD,
  parameter int FAST_PERIOD  = NAV_FAST_PERIOD,
  parameter int ACCEL_STEPS  = NAV_ACCEL_STEPS
) (
  input  logic clk_in,
  input  logic rst_n,
  input  logic BTN_EAST,
  input  logic BTN_WEST,
  input  logic BTN_NORTH,
  input  logic BTN_SOUTH,
  output logic dir_east,
  output logic dir_west,
  output logic dir_north,
  output logic dir_south,
  output logic move_tick,
  output logic repeat_fast
);

  localparam int INT_W = cnt_width(max3(FIRST_DELAY, SLOW_PERIOD, FAST_PERIOD));
  localparam int REP_W = cnt_width(ACCEL_STEPS);
  localparam logic [INT_W-1:0] FIRST_LAST = INT_W'(FIRST_DELAY - 1);
  localparam logic [INT_W-1:0] SLOW_LAST  = INT_W'(SLOW_PERIOD - 1);
  localparam logic [INT_W-1:0] FAST_LAST  = INT_W'(FAST_PERIOD - 1);
  localparam logic [INT_W-1:0] INT_SAT    = '1;
  localparam logic [REP_W-1:0] REP_LAST   = REP_W'(ACCEL_STEPS - 1);
  localparam logic [REP_W-1:0] REP_SAT    = REP_W'(ACCEL_STEPS);

  logic [3:0]       w_btn;
  logic [3:0]       w_pat;
  logic [3:0]       r_pat_q;
  nav_state_e       r_state;
  nav_state_e       w_state_nxt;
  logic [INT_W-1:0] r_int_cnt;
  logic [REP_W-1:0] r_rep_cnt;
  logic             r_move_tick;
  logic             r_pend;
  logic             w_tick;
  logic             w_pend_nxt;
  logic             w_int_clr;
  logic             w_rep_clr;
  logic             w_rep_inc;
  logic             w_chg;

  assign w_btn = {BTN_EAST, BTN_WEST, BTN_NORTH, BTN_SOUTH};

  for (genvar g = 0; g < 4; g++) begin : g_db
    nav_debounce #(
      .DEBOUNCE_CYC(DEBOUNCE_CYC)
    ) u_db (
      .i_clk  (clk_in),
      .i_rst_n(rst_n),
      .i_btn  (w_btn[g]),
      .o_level(w_pat[g])
    );
  end

  // State register
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and counter control
  always_comb begin
    w_state_nxt = r_state;
    w_tick      = 1'b0;
    w_pend_nxt  = 1'b0;
    w_int_clr   = 1'b0;
    w_rep_clr   = 1'b0;
    w_rep_inc   = 1'b0;
    // r_pend carries a pattern change that landed right after a tick
    w_chg       = (w_pat != r_pat_q) || r_pend;
    if (w_pat == 4'b0000) begin
      // release beats a coinciding interval expiry
      w_state_nxt = ST_IDLE;
      w_int_clr   = 1'b1;
      w_rep_clr   = 1'b1;
    end else if (w_chg) begin
      w_state_nxt = ST_FIRST;
      w_int_clr   = 1'b1;
      w_rep_clr   = 1'b1;
      // a tick went out this cycle: defer by one so strobes never abut
      if (r_move_tick) w_pend_nxt = 1'b1;
      else             w_tick     = 1'b1;
    end else begin
      unique case (r_state)
        ST_IDLE: w_int_clr = 1'b1;
        ST_FIRST: begin
          if (r_int_cnt == FIRST_LAST) begin
            w_tick      = 1'b1;
            w_int_clr   = 1'b1;
            w_rep_clr   = 1'b1;
            w_state_nxt = ST_SLOW;
          end
        end
        ST_SLOW: begin
          if (r_int_cnt == SLOW_LAST) begin
            w_tick    = 1'b1;
            w_int_clr = 1'b1;
            w_rep_inc = 1'b1;
            if (r_rep_cnt == REP_LAST) w_state_nxt = ST_FAST;
          end
        end
        ST_FAST: begin
          if (r_int_cnt == FAST_LAST) begin
            w_tick    = 1'b1;
            w_int_clr = 1'b1;
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_int_cnt   <= '0;
      r_rep_cnt   <= '0;
      r_pat_q     <= 4'b0000;
      r_move_tick <= 1'b0;
      r_pend      <= 1'b0;
    end else begin
      r_pat_q     <= w_pat;
      r_move_tick <= w_tick;
      r_pend      <= w_pend_nxt;
      if (w_int_clr)                  r_int_cnt <= '0;
      else if (r_int_cnt != INT_SAT)  r_int_cnt <= r_int_cnt + 1'b1;
      if (w_rep_clr)                  r_rep_cnt <= '0;
      else if (w_rep_inc && (r_rep_cnt != REP_SAT)) r_rep_cnt <= r_rep_cnt + 1'b1;
    end
  end

  // Outputs
  always_comb begin
    dir_east    = w_pat[3];
    dir_west    = w_pat[2];
    dir_north   = w_pat[1];
    dir_south   = w_pat[0];
    move_tick   = r_move_tick;
    repeat_fast = (r_state == ST_FAST);
  end

endmodule

// File: tb/tb_nav_button_conditioner.sv
module tb_nav_button_conditioner;

  logic clk_in = 1'b0;
  logic rst_n  = 1'b0;
  logic btn_e  = 1'b1;
  logic btn_w  = 1'b1;
  logic btn_n  = 1'b1;
  logic btn_s  = 1'b1;
  logic dir_east, dir_west, dir_north, dir_south;
  logic move_tick, repeat_fast;
  logic [3:0] pat;

  int n_tests   = 0;
  int n_fail    = 0;
  int win_ticks = 0;
  logic prev_tick = 1'b0;

  typedef struct {
    logic [3:0] btn;
    logic       rst;
    int         ncyc;
    logic [3:0] pat;
    logic       tick;
    logic       fast;
    int         ticks;
  } vec_t;

  vec_t vecs[17];
  int hold_ticks[12] = '{20, 25, 30, 35, 37, 39, 41, 43, 45, 47, 67, 72};

  nav_button_conditioner #(
    .DEBOUNCE_CYC(4),
    .FIRST_DELAY (20),
    .SLOW_PERIOD (5),
    .FAST_PERIOD (2),
    .ACCEL_STEPS (3)
  ) dut (
    .clk_in     (clk_in),
    .rst_n      (rst_n),
    .BTN_EAST   (btn_e),
    .BTN_WEST   (btn_w),
    .BTN_NORTH  (btn_n),
    .BTN_SOUTH  (btn_s),
    .dir_east   (dir_east),
    .dir_west   (dir_west),
    .dir_north  (dir_north),
    .dir_south  (dir_south),
    .move_tick  (move_tick),
    .repeat_fast(repeat_fast)
  );

  assign pat = {dir_east, dir_west, dir_north, dir_south};

  always #5 clk_in = ~clk_in;

  task automatic set_btn(input logic [3:0] b);
    {btn_e, btn_w, btn_n, btn_s} = b;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
    if (move_tick) win_ticks++;
    n_tests++;
    if (move_tick && prev_tick) begin
      n_fail++;
      $display("FAIL no_b2b: move_tick got 1 in two consecutive cycles, expected a gap (t=%0t)", $time);
    end
    prev_tick = move_tick;
  endtask

  function automatic bit tick_expected(input int r);
    bit hit = 1'b0;
    foreach (hold_ticks[i]) if (hold_ticks[i] == r) hit = 1'b1;
    return hit;
  endfunction

  initial begin
    // reset, release from reset mid-press, release
    vecs[0]  = '{4'b1111, 1'b0, 3,  4'b0000, 1'b0, 1'b0, 0};
    vecs[1]  = '{4'b1111, 1'b1, 5,  4'b0000, 1'b0, 1'b0, 0};
    vecs[2]  = '{4'b1111, 1'b1, 1,  4'b1111, 1'b0, 1'b0, 0};
    vecs[3]  = '{4'b1111, 1'b1, 1,  4'b1111, 1'b1, 1'b0, 1};
    vecs[4]  = '{4'b0000, 1'b1, 5,  4'b1111, 1'b0, 1'b0, 0};
    vecs[5]  = '{4'b0000, 1'b1, 1,  4'b0000, 1'b0, 1'b0, 0};
    vecs[6]  = '{4'b0000, 1'b1, 20, 4'b0000, 1'b0, 1'b0, 0};
    // 3-cycle glitch rejected
    vecs[7]  = '{4'b1000, 1'b1, 3,  4'b0000, 1'b0, 1'b0, 0};
    vecs[8]  = '{4'b0000, 1'b1, 10, 4'b0000, 1'b0, 1'b0, 0};
    // 4-cycle pulse is exactly long enough
    vecs[9]  = '{4'b1000, 1'b1, 4,  4'b0000, 1'b0, 1'b0, 0};
    vecs[10] = '{4'b0000, 1'b1, 2,  4'b1000, 1'b0, 1'b0, 0};
    vecs[11] = '{4'b0000, 1'b1, 1,  4'b1000, 1'b1, 1'b0, 1};
    vecs[12] = '{4'b0000, 1'b1, 3,  4'b0000, 1'b0, 1'b0, 0};
    vecs[13] = '{4'b0000, 1'b1, 25, 4'b0000, 1'b0, 1'b0, 0};
    // opposing buttons pass through
    vecs[14] = '{4'b1100, 1'b1, 7,  4'b1100, 1'b1, 1'b0, 1};
    vecs[15] = '{4'b0000, 1'b1, 6,  4'b0000, 1'b0, 1'b0, 0};
    vecs[16] = '{4'b0000, 1'b1, 25, 4'b0000, 1'b0, 1'b0, 0};

    for (int i = 0; i < 17; i++) begin
      set_btn(vecs[i].btn);
      rst_n = vecs[i].rst;
      win_ticks = 0;
      repeat (vecs[i].ncyc) step();
      check($sformatf("vec%0d_pat", i),   32'(pat),         32'(vecs[i].pat));
      check($sformatf("vec%0d_tick", i),  32'(move_tick),   32'(vecs[i].tick));
      check($sformatf("vec%0d_fast", i),  32'(repeat_fast), 32'(vecs[i].fast));
      check($sformatf("vec%0d_ticks", i), 32'(win_ticks),   32'(vecs[i].ticks));
    end

    // hold north: repeat cadence, add east in FAST, release in SLOW
    set_btn(4'b0010);
    repeat (7) step();
    check("hold_first_tick", 32'(move_tick), 32'd1);
    check("hold_first_pat",  32'(pat),       32'h2);
    for (int r = 1; r <= 100; r++) begin
      step();
      check($sformatf("hold_tick[%0d]", r), 32'(move_tick), 32'(tick_expected(r)));
      check($sformatf("hold_fast[%0d]", r), 32'(repeat_fast), 32'((r >= 35) && (r <= 46)));
      check($sformatf("hold_pat[%0d]", r),  32'(pat),
            (r < 46) ? 32'h2 : ((r < 76) ? 32'hA : 32'h0));
      if (r == 40) set_btn(4'b1010);
      if (r == 70) set_btn(4'b0000);
    end

    // async reset while in FAST
    set_btn(4'b0010);
    repeat (7) step();
    check("ar_first_tick", 32'(move_tick), 32'd1);
    repeat (35) step();
    check("ar_fast_tick", 32'(move_tick),   32'd1);
    check("ar_fast",      32'(repeat_fast), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("ar_clr_pat",  32'(pat),         32'h0);
    check("ar_clr_tick", 32'(move_tick),   32'd0);
    check("ar_clr_fast", 32'(repeat_fast), 32'd0);
    win_ticks = 0;
    repeat (4) step();
    check("ar_hold_ticks", 32'(win_ticks), 32'd0);
    check("ar_hold_pat",   32'(pat),       32'h0);
    rst_n = 1'b1;
    repeat (6) step();
    check("ar_rel_pat",  32'(pat),       32'h2);
    check("ar_rel_tick", 32'(move_tick), 32'd0);
    step();
    check("ar_rel_tick7", 32'(move_tick), 32'd1);
    set_btn(4'b0000);
    repeat (10) step();
    check("ar_end_pat", 32'(pat), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
